// File: rtl/apb_counter_regs_if.sv
// ---------------------------------------------------------------------------
// apb_counter_regs_if
//   APB3 signal bundle between the interconnect (master) and the counter
//   register front-end (slave).
//
//   psel, penable, pwrite  : transfer control (master -> slave)
//   paddr  [ADDR_W]        : byte address (master -> slave)
//   pwdata [DATA_W]        : write data (master -> slave)
//   prdata [DATA_W]        : read data (slave -> master)
//   pready                 : transfer complete (slave -> master)
//   pslverr                : transfer error (slave -> master)
// ---------------------------------------------------------------------------
interface apb_counter_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_counter_regs.sv
// ---------------------------------------------------------------------------
// apb_counter_regs
//   APB3 register front-end for the mod-(MOD_MAX+1) counter stage. Drives the
//   counter enable and clear, samples the counter value, counts MOD_MAX->0
//   wrap events, flags illegal counter values and raises a level interrupt
//   on wrap.
//
//   Register map (word offsets):
//     0x0 CTRL   RW  bit0 EN, bit1 IRQ_EN, bit2 SOFT_CLR (write-1 pulse, reads 0)
//     0x4 VALUE  RO  {zeros, cnt_q}
//     0x8 WRAPS  RW  {zeros, wrap_cnt}, any write clears
//     0xC STATUS W1C bit0 WRAP_PEND, bit1 ERR
//
//   Ports:
//     clk      : clock, rising edge
//     reset_n  : synchronous active-low reset
//     apb      : APB3 slave bundle (apb_counter_regs_if.slave)
//     cnt_q    : counter value from the counter stage
//     cnt_en   : counter run enable (CTRL.EN)
//     cnt_clr  : one-cycle counter clear pulse
//     irq      : level interrupt, IRQ_EN & WRAP_PEND
//
//   APB FSM:
//     state  | meaning
//     IDLE   | no transfer in progress; waits for psel & !penable
//     SETUP  | address phase seen; read data is captured leaving this state
//     ACCESS | pready asserted while psel & penable; writes commit at its end
// ---------------------------------------------------------------------------
module apb_counter_regs #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int WRAP_W  = 16,
    parameter int MOD_MAX = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    apb_counter_regs_if.slave        apb,
    input  logic [3:0]               cnt_q,
    output logic                     cnt_en,
    output logic                     cnt_clr,
    output logic                     irq
);

    localparam logic [3:0] MOD_MAX_Q = 4'(MOD_MAX);

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_VALUE  = 2'd1;
    localparam logic [1:0] IDX_WRAPS  = 2'd2;
    localparam logic [1:0] IDX_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Register state
    logic                ctrl_en;
    logic                ctrl_irq_en;
    logic                clr_pulse;
    logic                clr_d;
    logic [3:0]          q_prev;
    logic [WRAP_W-1:0]   wrap_cnt;
    logic                wrap_pend;
    logic                err_flag;
    logic [DATA_W-1:0]   prdata_q;

    // Decode / strobes
    logic [1:0]          reg_idx;
    logic                addr_err;
    logic                xfer_err;
    logic                access_hit;
    logic                wr_commit;
    logic                wr_ctrl;
    logic                wr_wraps;
    logic                wr_status;
    logic [DATA_W-1:0]   rd_data;
    logic                wrap_evt;
    logic                illegal_q;
    logic                unused_pwdata;

    assign unused_pwdata = ^apb.pwdata[DATA_W-1:3];

    // -----------------------------------------------------------------------
    // Address decode and error classification
    // -----------------------------------------------------------------------
    assign reg_idx  = apb.paddr[3:2];
    assign addr_err = (apb.paddr[1:0] != 2'b00) || (32'(apb.paddr) > 32'hC);
    // VALUE is read-only; a write to it is reported rather than ignored.
    assign xfer_err = addr_err || (apb.pwrite && (reg_idx == IDX_VALUE));

    // -----------------------------------------------------------------------
    // APB FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // APB FSM: next state and transfer strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        access_hit = 1'b0;
        unique case (state)
            IDLE: begin
                // psel & penable here is a protocol violation: no response.
                if (apb.psel && !apb.penable) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                access_hit = apb.psel && apb.penable;
                if (apb.psel && !apb.penable) begin
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign wr_commit = access_hit && apb.pwrite && !xfer_err;
    assign wr_ctrl   = wr_commit && (reg_idx == IDX_CTRL);
    assign wr_wraps  = wr_commit && (reg_idx == IDX_WRAPS);
    assign wr_status = wr_commit && (reg_idx == IDX_STATUS);

    assign apb.pready  = access_hit;
    assign apb.pslverr = access_hit && xfer_err;
    assign apb.prdata  = prdata_q;

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        unique case (reg_idx)
            IDX_CTRL:   rd_data = DATA_W'({ctrl_irq_en, ctrl_en});
            IDX_VALUE:  rd_data = DATA_W'(cnt_q);
            IDX_WRAPS:  rd_data = DATA_W'(wrap_cnt);
            IDX_STATUS: rd_data = DATA_W'({err_flag, wrap_pend});
            default:    rd_data = '0;
        endcase
    end

    // prdata is captured on the SETUP->ACCESS edge and held zero elsewhere,
    // so it never glitches with the live address or counter value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prdata_q <= '0;
        end else if (state == SETUP && !apb.pwrite && !xfer_err) begin
            prdata_q <= rd_data;
        end else begin
            prdata_q <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Counter monitoring
    // -----------------------------------------------------------------------
    // clr_d masks the MOD_MAX->0 step caused by our own clear pulse.
    assign wrap_evt  = (q_prev == MOD_MAX_Q) && (cnt_q == 4'd0) && !clr_d;
    assign illegal_q = cnt_q > MOD_MAX_Q;

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            clr_pulse   <= 1'b0;
            clr_d       <= 1'b0;
            q_prev      <= 4'd0;
            wrap_cnt    <= '0;
            wrap_pend   <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            q_prev    <= cnt_q;
            clr_d     <= clr_pulse;
            clr_pulse <= wr_ctrl && apb.pwdata[2];

            if (wr_ctrl) begin
                ctrl_en     <= apb.pwdata[0];
                ctrl_irq_en <= apb.pwdata[1];
            end

            // A clearing write that coincides with a wrap keeps that wrap.
            if (wr_wraps) begin
                wrap_cnt <= wrap_evt ? WRAP_W'(1) : '0;
            end else if (wrap_evt && (wrap_cnt != '1)) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end

            // W1C with set priority: a new event is never lost to a clear.
            wrap_pend <= (wrap_pend && !(wr_status && apb.pwdata[0])) || wrap_evt;
            err_flag  <= (err_flag  && !(wr_status && apb.pwdata[1])) || illegal_q;
        end
    end

    assign cnt_en  = ctrl_en;
    assign cnt_clr = clr_pulse;
    assign irq     = ctrl_irq_en && wrap_pend;

endmodule

// File: tb/tb_apb_counter_regs.sv
// ---------------------------------------------------------------------------
// tb_apb_counter_regs
//   Directed bench for apb_counter_regs. The counter stage is modelled by a
//   bench-loaded register that also honours cnt_clr. ADDR_W is widened to 5
//   so offset 0x10 is addressable, and WRAP_W is reduced to 8 so saturation
//   of the wrap counter is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_apb_counter_regs;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int WRAP_W = 8;
    localparam logic [31:0] WRAP_MAX = 32'hFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  cnt_q;
    logic        cnt_en;
    logic        cnt_clr;
    logic        irq;
    logic        load_en;
    logic [3:0]  load_val;

    int n_checks = 0;
    int n_fail   = 0;

    apb_counter_regs_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_counter_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WRAP_W (WRAP_W),
        .MOD_MAX(5)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .apb    (apb),
        .cnt_q  (cnt_q),
        .cnt_en (cnt_en),
        .cnt_clr(cnt_clr),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Counter stage model: clear has priority, otherwise bench loads.
    always @(posedge clk) begin
        if (cnt_clr === 1'b1) cnt_q <= 4'd0;
        else if (load_en)     cnt_q <= load_val;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                            input bit wrap_hit, output logic [31:0] rdata, output logic err);
        int waited;
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
        apb.paddr = addr; apb.pwdata = wdata;
        if (wrap_hit) begin load_val = 4'd5; load_en = 1'b1; end
        @(negedge clk);
        check_val("pready_setup", 32'(apb.pready), 32'd0);
        check_val("prdata_setup", apb.prdata, 32'd0);
        apb.penable = 1'b1;
        if (wrap_hit) load_val = 4'd0;
        @(negedge clk);
        if (wrap_hit) load_en = 1'b0;
        waited = 0;
        while (apb.pready !== 1'b1 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check_val("pready_access", 32'(apb.pready), 32'd1);
        rdata = apb.prdata;
        err   = apb.pslverr;
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic reg_wr(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] d, input bit exp_err);
        logic [31:0] r;
        logic        e;
        apb_xfer(1'b1, addr, d, 1'b0, r, e);
        check_val({tag, "_slverr"}, 32'(e), 32'(exp_err));
        if (exp_err) check_val({tag, "_prdata"}, r, 32'd0);
    endtask

    task automatic reg_rd(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp, input bit exp_err);
        logic [31:0] r;
        logic        e;
        apb_xfer(1'b0, addr, 32'd0, 1'b0, r, e);
        check_val(tag, r, exp);
        check_val({tag, "_slverr"}, 32'(e), 32'(exp_err));
    endtask

    task automatic drive_q(input logic [3:0] v);
        @(negedge clk); load_val = v; load_en = 1'b1;
        @(negedge clk); load_en = 1'b0;
    endtask

    // 1,2,3,4,5,0 on consecutive cycles; returns in the cycle after the 5->0 step.
    task automatic count_cycle();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); load_en = 1'b1; load_val = 4'(i % 6);
        end
        @(negedge clk); load_en = 1'b0;
    endtask

    task automatic wrap_pulse();
        @(negedge clk); load_en = 1'b1; load_val = 4'd5;
        @(negedge clk); load_val = 4'd0;
        @(negedge clk); load_en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        e;

        reset_n = 1'b0; load_en = 1'b1; load_val = 4'd0;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;
        repeat (3) @(negedge clk);
        check_val("rst_prdata",  apb.prdata, 32'd0);
        check_val("rst_pready",  32'(apb.pready), 32'd0);
        check_val("rst_pslverr", 32'(apb.pslverr), 32'd0);
        check_val("rst_cnt_en",  32'(cnt_en), 32'd0);
        check_val("rst_cnt_clr", 32'(cnt_clr), 32'd0);
        check_val("rst_irq",     32'(irq), 32'd0);
        reset_n = 1'b1; load_en = 1'b0;

        // Reset values of all registers
        reg_rd("rst_ctrl",   5'h0, 32'h0, 1'b0);
        reg_rd("rst_value",  5'h4, 32'h0, 1'b0);
        reg_rd("rst_wraps",  5'h8, 32'h0, 1'b0);
        reg_rd("rst_status", 5'hC, 32'h0, 1'b0);

        // Enable + IRQ enable, two wraps
        reg_wr("ctrl3", 5'h0, 32'h3, 1'b0);
        check_val("cnt_en_on", 32'(cnt_en), 32'd1);
        @(negedge clk);
        check_val("no_clr_ctrl3", 32'(cnt_clr), 32'd0);
        count_cycle();
        check_val("irq_at_w", 32'(irq), 32'd0);
        @(negedge clk);
        check_val("irq_at_w1", 32'(irq), 32'd1);
        count_cycle();
        reg_rd("value0",      5'h4, 32'h0, 1'b0);
        reg_rd("wraps2",      5'h8, 32'h2, 1'b0);
        reg_rd("status_pend", 5'hC, 32'h1, 1'b0);
        check_val("irq_pend", 32'(irq), 32'd1);
        reg_wr("w1c_pend", 5'hC, 32'h1, 1'b0);
        @(negedge clk);
        check_val("irq_cleared", 32'(irq), 32'd0);
        reg_rd("status_clr", 5'hC, 32'h0, 1'b0);

        // Soft clear while the counter sits at 5 must not count as a wrap
        drive_q(4'd5);
        reg_rd("value5", 5'h4, 32'h5, 1'b0);
        reg_wr("ctrl5", 5'h0, 32'h5, 1'b0);
        @(negedge clk);
        check_val("clr_pulse", 32'(cnt_clr), 32'd1);
        @(negedge clk);
        check_val("clr_done",  32'(cnt_clr), 32'd0);
        check_val("q_cleared", 32'(cnt_q), 32'd0);
        reg_rd("wraps_after_clr",  5'h8, 32'h2, 1'b0);
        reg_rd("status_after_clr", 5'hC, 32'h0, 1'b0);
        reg_rd("ctrl_rb",          5'h0, 32'h1, 1'b0);

        // Erroring transfers
        reg_wr("wr_value", 5'h04, 32'hF, 1'b1);
        reg_wr("wr_unal",  5'h02, 32'h7, 1'b1);
        reg_wr("wr_oob",   5'h10, 32'h6, 1'b1);
        reg_rd("rd_oob",   5'h10, 32'h0, 1'b1);
        reg_rd("rd_unal",  5'h09, 32'h0, 1'b1);
        reg_rd("ctrl_after_err",  5'h0, 32'h1, 1'b0);
        reg_rd("wraps_after_err", 5'h8, 32'h2, 1'b0);
        check_val("no_clr_err", 32'(cnt_clr), 32'd0);

        // Illegal counter value, W1C loses to a concurrent set
        drive_q(4'd7);
        reg_rd("value7",     5'h4, 32'h7, 1'b0);
        reg_rd("status_err", 5'hC, 32'h2, 1'b0);
        reg_wr("w1c_err_held", 5'hC, 32'h2, 1'b0);
        reg_rd("status_err_held", 5'hC, 32'h2, 1'b0);
        drive_q(4'd0);
        reg_wr("w1c_err", 5'hC, 32'h2, 1'b0);
        reg_rd("status_err_clr", 5'hC, 32'h0, 1'b0);

        // Saturation
        reg_wr("wraps_clr", 5'h8, 32'hABCD, 1'b0);
        reg_rd("wraps_zero", 5'h8, 32'h0, 1'b0);
        repeat (int'(WRAP_MAX)) wrap_pulse();
        reg_rd("wraps_max", 5'h8, WRAP_MAX, 1'b0);
        wrap_pulse();
        reg_rd("wraps_sat",   5'h8, WRAP_MAX, 1'b0);
        reg_rd("status_sat",  5'hC, 32'h1, 1'b0);
        check_val("irq_masked", 32'(irq), 32'd0);

        // WRAPS write coinciding with a wrap event
        apb_xfer(1'b1, 5'h8, 32'h0, 1'b1, r, e);
        check_val("wraps_hit_slverr", 32'(e), 32'd0);
        reg_rd("wraps_hit", 5'h8, 32'h1, 1'b0);

        // psel & penable from IDLE gets no response and commits nothing
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b1;
        apb.paddr = 5'h0; apb.pwdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("viol_pready", 32'(apb.pready), 32'd0);
        end
        apb.psel = 1'b0; apb.penable = 1'b0;
        reg_rd("ctrl_after_viol", 5'h0, 32'h1, 1'b0);

        // Reset in the middle of a transfer
        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = 5'h0; apb.pwdata = 32'h3;
        @(negedge clk);
        apb.penable = 1'b1; reset_n = 1'b0;
        @(negedge clk);
        check_val("midrst_pready", 32'(apb.pready), 32'd0);
        check_val("midrst_cnt_en", 32'(cnt_en), 32'd0);
        reset_n = 1'b1; apb.psel = 1'b0; apb.penable = 1'b0;
        reg_rd("midrst_ctrl",   5'h0, 32'h0, 1'b0);
        reg_rd("midrst_wraps",  5'h8, 32'h0, 1'b0);
        reg_rd("midrst_status", 5'hC, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_counter_regs.md
# apb_counter_regs

APB3 slave register front-end for the mod-6 counter stage. It drives the counter's enable and clear controls, samples its 4-bit `q` output, counts 5→0 wrap events, flags illegal counter values, and raises a level interrupt on wrap. It sits between the APB interconnect and the counter, on the same clock and reset.

## Interface
- `ADDR_W`, 4: APB address width. Byte addresses; only word offsets 0x0–0xC are decoded.
- `DATA_W`, 32: APB data width.
- `WRAP_W`, 16: width of the wrap-event counter.
- `MOD_MAX`, 5: terminal count of the downstream counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `psel`, `penable`, `pwrite` in 1: APB control.
- `paddr` in ADDR_W: APB address.
- `pwdata` in DATA_W: APB write data.
- `prdata` out DATA_W: APB read data.
- `pready` out 1: transfer complete.
- `pslverr` out 1: transfer error.
- `cnt_q` in 4: counter value from the counter stage.
- `cnt_en` out 1: counter run enable.
- `cnt_clr` out 1: one-cycle counter clear pulse.
- `irq` out 1: level interrupt.

## Operation
- Register map:
  - 0x0 CTRL (RW): bit0 EN, bit1 IRQ_EN, bit2 SOFT_CLR. SOFT_CLR is write-1-pulse and always reads 0.
  - 0x4 VALUE (RO): {zeros, `cnt_q`}.
  - 0x8 WRAPS (RW): {zeros, wrap_cnt}. Any write clears it.
  - 0xC STATUS (W1C): bit0 WRAP_PEND, bit1 ERR.
- APB FSM states are IDLE, SETUP and ACCESS:
  - IDLE → SETUP on `psel & !penable`.
  - SETUP → ACCESS unconditionally.
  - ACCESS → SETUP if `psel & !penable`, else IDLE.
  - `psel & penable` seen while in IDLE is a protocol violation. It gets no response: `pready` stays 0 and no state changes.
- `pready`: 1 exactly while in ACCESS with `psel & penable`. Zero wait states.
- Commit point: writes take effect on the rising edge that ends ACCESS.
- `prdata`: registered at the SETUP→ACCESS edge and valid throughout ACCESS. It is 0 in every other state.
- `pslverr`: asserted only in ACCESS, alongside `pready`, when either:
  - `paddr[1:0]` ≠ 0, or `paddr` > 0xC; or
  - the transfer is a write to VALUE.
  An erroring transfer changes no state, and its `prdata` is 0.
- `cnt_en` = CTRL.EN.
- `cnt_clr`: 1 for exactly the cycle after a committed CTRL write with bit2 = 1. It is independent of EN.
- Wrap detection uses `q_prev`, which registers `cnt_q` every cycle.
  - Wrap event = `q_prev == MOD_MAX && cnt_q == 0 && !clr_d`, where `clr_d` is `cnt_clr` delayed one cycle. Clears therefore never count as wraps.
  - On a wrap event, wrap_cnt increments, saturating at all-ones, and WRAP_PEND is set.
- Illegal value: `cnt_q > MOD_MAX` in any cycle sets ERR.
- Simultaneous events:
  - WAIT write and a wrap event in the same cycle: wrap_cnt becomes 1.
  - STATUS W1C and a set in the same cycle: the set wins and the bit stays 1.
- `irq` = IRQ_EN & WRAP_PEND, driven from flops with no combinational path from APB inputs.

## Timing
- Reset (`reset_n` low at a rising edge):
  - CTRL, wrap_cnt, STATUS, `q_prev`, `clr_d` and the FSM (IDLE) all clear.
  - Outputs on the following cycle: `prdata` = 0, `pready` = 0, `pslverr` = 0, `cnt_en` = 0, `cnt_clr` = 0, `irq` = 0.
- Reset mid-transfer: the transfer is abandoned with no commit, and the bus restarts from IDLE.
- APB transfer latency: 2 cycles (SETUP + ACCESS). Back-to-back transfers every 2 cycles.
- CTRL write committed at edge E:
  - `cnt_en` changes at E.
  - `cnt_clr` is high in the cycle following E.
- Counter `cnt_q` goes 5→0 at edge W:
  - wrap_cnt and WRAP_PEND update at W+1.
  - `irq` rises at W+1 if IRQ_EN is set.
- A VALUE read returns `cnt_q` as sampled at the SETUP→ACCESS edge.

## Test plan
- Reset, then read all four registers → 0x0, 0x0, 0x0, 0x0. `cnt_en`, `cnt_clr`, `irq` all 0. `pready` is 1 only in ACCESS.
- Write CTRL = 0x3, then let the model counter run 0→5→0 twice → WRAPS = 2, STATUS = 0x1, `irq` = 1. Write STATUS = 0x1 → `irq` drops and STATUS = 0x0.
- With `cnt_q` = 5, write CTRL = 0x5 → `cnt_clr` pulses for one cycle, `cnt_q` → 0, WRAPS unchanged, WRAP_PEND stays 0.
- Write to 0x4, 0x2 and 0x10 → `pslverr` = 1 on each, no register change. A read of 0x10 returns 0 with `pslverr` = 1.
- Force `cnt_q` = 7 for one cycle → STATUS.ERR = 1. A W1C of 0x2 issued while `cnt_q` is still 7 leaves ERR = 1.
- Preload wrap_cnt to 0xFFFF via repeated wraps, then wrap once more → stays 0xFFFF. A WRAPS write coinciding with a wrap event reads back 1.
